// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer. It chooses the next fetch address from the
//   decoded control of the instruction at pc and supports a single-instruction
//   EXEC excursion. EXEC jumps to rs_data, runs exactly one instruction there,
//   and then returns to the instruction after the EXEC.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hold all state for this cycle
//   branch       in   conditional branch at pc
//   jal          in   jump-and-link at pc
//   jr           in   jump to register at pc
//   exec         in   execute-one-at-register at pc
//   cond[2:0]    in   branch condition code
//   flag[2:0]    in   {Z,V,N}
//   br_offset    in   signed 8-bit branch displacement (relative to pc+1)
//   jal_offset   in   signed 12-bit jump displacement (relative to pc+1)
//   rs_data      in   register target for jr / exec
//   pc           out  registered address of the instruction being decoded
//   link_addr    out  registered return address written by jal
//   flush        out  one-cycle pulse after any non-sequential pc load
//   exec_active  out  high while the EXEC target instruction is in flight
// ---------------------------------------------------------------------------
module pc_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        jal,
  input  logic        jr,
  input  logic        exec,
  input  logic [2:0]  cond,
  input  logic [2:0]  flag,
  input  logic [7:0]  br_offset,
  input  logic [11:0] jal_offset,
  input  logic [15:0] rs_data,
  output logic [15:0] pc,
  output logic [15:0] link_addr,
  output logic        flush,
  output logic        exec_active
);

  typedef enum logic {RUN, EXEC_ONE} state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_link;
  logic [15:0] r_ret;
  logic        r_flush;

  logic [15:0] w_seq;
  logic [15:0] w_br_target;
  logic [15:0] w_jal_target;
  logic        w_taken;
  logic        w_z;
  logic        w_v;
  logic        w_n;

  assign w_z = flag[2];
  assign w_v = flag[1];
  assign w_n = flag[0];

  // Both displacements are relative to the sequential address, and all
  // arithmetic wraps at 16 bits.
  assign w_seq        = r_pc + 16'd1;
  assign w_br_target  = w_seq + {{8{br_offset[7]}}, br_offset};
  assign w_jal_target = w_seq + {{4{jal_offset[11]}}, jal_offset};

  always_comb begin
    w_taken = 1'b0;
    case (cond)
      3'b000: w_taken = w_z;
      3'b001: w_taken = ~w_z;
      3'b010: w_taken = ~w_z & ~w_n;
      3'b011: w_taken = w_n;
      3'b100: w_taken = w_z | (~w_z & ~w_n);
      3'b101: w_taken = w_n | w_z;
      3'b110: w_taken = w_v;
      3'b111: w_taken = 1'b1;
      default: w_taken = 1'b0;
    endcase
  end

  // flush is raised for every non-sequential load, including a taken branch
  // whose target happens to equal seq; it is not derived by comparing
  // addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_pc    <= 16'h0000;
      r_link  <= 16'h0000;
      r_ret   <= 16'h0000;
      r_flush <= 1'b0;
    end else if (stall) begin
      r_flush <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (jr) begin
            r_pc    <= rs_data;
            r_flush <= 1'b1;
          end else if (jal) begin
            r_pc    <= w_jal_target;
            r_link  <= w_seq;
            r_flush <= 1'b1;
          end else if (exec) begin
            r_pc    <= rs_data;
            r_ret   <= w_seq;
            r_state <= EXEC_ONE;
            r_flush <= 1'b1;
          end else if (branch && w_taken) begin
            r_pc    <= w_br_target;
            r_flush <= 1'b1;
          end else begin
            r_pc    <= w_seq;
            r_flush <= 1'b0;
          end
        end
        EXEC_ONE: begin
          // The control of the EXEC target is ignored: it runs as one
          // instruction, and the only redirect is the return.
          r_pc    <= r_ret;
          r_state <= RUN;
          r_flush <= 1'b1;
        end
        default: begin
          r_state <= RUN;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = r_pc;
  assign link_addr   = r_link;
  assign flush       = r_flush;
  assign exec_active = (r_state == EXEC_ONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Self-checking bench for pc_sequencer. It runs a table of directed vectors
//   from reset, a hand-written reset-during-EXEC sequence, and a randomized
//   phase that is checked against an abstract next-address model.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch;
  logic        jal;
  logic        jr;
  logic        exec;
  logic [2:0]  cond;
  logic [2:0]  flag;
  logic [7:0]  br_offset;
  logic [11:0] jal_offset;
  logic [15:0] rs_data;
  logic [15:0] pc;
  logic [15:0] link_addr;
  logic        flush;
  logic        exec_active;

  int total = 0;
  int bad   = 0;

  pc_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .branch      (branch),
    .jal         (jal),
    .jr          (jr),
    .exec        (exec),
    .cond        (cond),
    .flag        (flag),
    .br_offset   (br_offset),
    .jal_offset  (jal_offset),
    .rs_data     (rs_data),
    .pc          (pc),
    .link_addr   (link_addr),
    .flush       (flush),
    .exec_active (exec_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model -----------------
  // The model tracks what the program counter should be, and nothing about
  // the hardware's encoding: a pc, a link register, an optional pending
  // return address, and whether the last edge redirected.
  logic [15:0] m_pc;
  logic [15:0] m_link;
  logic [15:0] m_ret;
  bit          m_in_exec;
  bit          m_flush;

  function automatic bit m_taken(input logic [2:0] c, input logic [2:0] f);
    bit z, v, n;
    z = f[2]; v = f[1]; n = f[0];
    case (c)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !(z || n);
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return z || n;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 16'h0; m_link = 16'h0; m_ret = 16'h0;
    m_in_exec = 0; m_flush = 0;
  endtask

  task automatic model_edge();
    int seq;
    if (stall) begin
      m_flush = 0;
    end else if (m_in_exec) begin
      m_pc = m_ret; m_in_exec = 0; m_flush = 1;
    end else begin
      seq = int'(m_pc) + 1;
      m_flush = 1;
      if (jr) m_pc = rs_data;
      else if (jal) begin
        m_link = 16'(seq);
        m_pc   = 16'(seq + int'($signed(jal_offset)));
      end else if (exec) begin
        m_ret = 16'(seq); m_pc = rs_data; m_in_exec = 1;
      end else if (branch && m_taken(cond, flag))
        m_pc = 16'(seq + int'($signed(br_offset)));
      else begin
        m_pc = 16'(seq); m_flush = 0;
      end
    end
  endtask

  // ---------------- helpers -----------------
  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    stall = 0; branch = 0; jal = 0; jr = 0; exec = 0;
    cond = 3'd0; flag = 3'd0; br_offset = 8'd0; jal_offset = 12'd0; rs_data = 16'd0;
  endtask

  // Advance one rising edge and sample 1 ns later; the model follows the
  // same inputs that were stable across the edge.
  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  // ---------------- directed vector table -----------------
  typedef struct {
    logic        stall, branch, jal, jr, exec;
    logic [2:0]  cond, flag;
    logic [7:0]  br;
    logic [11:0] jo;
    logic [15:0] rs;
    logic [15:0] e_pc, e_link;
    logic        e_flush, e_exec;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic j, input logic r,
                              input logic x, input logic [2:0] c, input logic [2:0] f,
                              input logic [7:0] bo, input logic [11:0] jo, input logic [15:0] rs,
                              input logic [15:0] epc, input logic [15:0] elink,
                              input logic efl, input logic eex);
    vec_t v;
    v.stall = s; v.branch = b; v.jal = j; v.jr = r; v.exec = x;
    v.cond = c; v.flag = f; v.br = bo; v.jo = jo; v.rs = rs;
    v.e_pc = epc; v.e_link = elink; v.e_flush = efl; v.e_exec = eex;
    return v;
  endfunction

  initial begin
    string nm;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();

    //            st b  jl jr ex cond  flag  br     jo      rs        pc       link    fl ex
    // sequential fetch from reset
    vecs.push_back(mk(0,0,0,0,0,3'd0,3'b000,8'h00,12'h000,16'h0000,16'h0001,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'd0,3'b000,8'h00,12'h000,16'h0000,16'h0002,16'h0000,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'd0,3'b000,8'h00,12'h000,16'h0000,16'h0003,16'h0000,0,0));
    // branch on Z taken backward, then not taken
    vecs.push_back(mk(0,0,0,1,0,3'd0,3'b000,8'h00,12'h000,16'h0010,16'h0010,16'h0000,1,0));
    vecs.push_back(mk(0,1,0,0,0,3'd0,3'b100,8'hFE,12'h000,16'h0000,16'h000F,16'h0000,1,0));
    vecs.push_back(mk(0,0,0,1,0,3'd0,3'b000,8'h00,12'h000,16'h0010,16'h0010,16'h0000,1,0));
    vecs.push_back(mk(0,1,0,0,0,3'd0,3'b000,8'hFE,12'h000,16'h0000,16'h0011,16'h0000,0,0));
    // jal across the top of the address space
    vecs.push_back(mk(0,0,0,1,0,3'd0,3'b000,8'h00,12'h000,16'hFFFE,16'hFFFE,16'h0000,1,0));
    vecs.push_back(mk(0,0,1,0,0,3'd0,3'b000,8'h00,12'h003,16'h0000,16'h0002,16'hFFFF,1,0));
    // exec excursion; the branch at the target is ignored
    vecs.push_back(mk(0,0,0,1,0,3'd0,3'b000,8'h00,12'h000,16'h0020,16'h0020,16'hFFFF,1,0));
    vecs.push_back(mk(0,0,0,0,1,3'd0,3'b000,8'h00,12'h000,16'h0100,16'h0100,16'hFFFF,1,1));
    vecs.push_back(mk(0,1,0,0,0,3'd7,3'b000,8'h05,12'h000,16'h0000,16'h0021,16'hFFFF,1,0));
    // stalled jr+jal: hold two cycles, then jr wins and link is untouched
    vecs.push_back(mk(1,0,1,1,0,3'd0,3'b000,8'h00,12'h010,16'h0555,16'h0021,16'hFFFF,0,0));
    vecs.push_back(mk(1,0,1,1,0,3'd0,3'b000,8'h00,12'h010,16'h0555,16'h0021,16'hFFFF,0,0));
    vecs.push_back(mk(0,0,1,1,0,3'd0,3'b000,8'h00,12'h010,16'h0555,16'h0555,16'hFFFF,1,0));
    // taken branch with zero offset still flushes
    vecs.push_back(mk(0,1,0,0,0,3'd7,3'b000,8'h00,12'h000,16'h0000,16'h0556,16'hFFFF,1,0));
    vecs.push_back(mk(0,0,0,0,0,3'd0,3'b000,8'h00,12'h000,16'h0000,16'h0557,16'hFFFF,0,0));
    // stall inside EXEC_ONE, then nested exec/jal at the target are ignored
    vecs.push_back(mk(0,0,0,0,1,3'd0,3'b000,8'h00,12'h000,16'h0200,16'h0200,16'hFFFF,1,1));
    vecs.push_back(mk(1,0,0,0,0,3'd0,3'b000,8'h00,12'h000,16'h0000,16'h0200,16'hFFFF,0,1));
    vecs.push_back(mk(0,0,1,0,1,3'd0,3'b000,8'h00,12'h040,16'h0300,16'h0558,16'hFFFF,1,0));

    // ---- reset values, checked before any clock edge ----
    #1;
    check16("reset_pc", pc, 16'h0000);
    check16("reset_link", link_addr, 16'h0000);
    check1("reset_flush", flush, 1'b0);
    check1("reset_exec", exec_active, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < vecs.size(); i++) begin
      stall = vecs[i].stall; branch = vecs[i].branch; jal = vecs[i].jal;
      jr = vecs[i].jr; exec = vecs[i].exec; cond = vecs[i].cond; flag = vecs[i].flag;
      br_offset = vecs[i].br; jal_offset = vecs[i].jo; rs_data = vecs[i].rs;
      step();
      $display("vec %0d: pc=%h link=%h flush=%b exec_active=%b", i, pc, link_addr, flush, exec_active);
      nm = $sformatf("vec%0d_pc", i);    check16(nm, pc, vecs[i].e_pc);
      nm = $sformatf("vec%0d_link", i);  check16(nm, link_addr, vecs[i].e_link);
      nm = $sformatf("vec%0d_flush", i); check1(nm, flush, vecs[i].e_flush);
      nm = $sformatf("vec%0d_exec", i);  check1(nm, exec_active, vecs[i].e_exec);
    end

    // ---- randomized phase against the model ----
    for (int i = 0; i < 400; i++) begin
      stall      = ($urandom_range(0, 4) == 0);
      branch     = ($urandom_range(0, 2) == 0);
      jal        = ($urandom_range(0, 7) == 0);
      jr         = ($urandom_range(0, 9) == 0);
      exec       = ($urandom_range(0, 7) == 0);
      cond       = 3'($urandom_range(0, 7));
      flag       = 3'($urandom_range(0, 7));
      br_offset  = 8'($urandom);
      jal_offset = 12'($urandom);
      rs_data    = 16'($urandom);
      step();
      $display("rnd %0d: pc=%h link=%h flush=%b exec_active=%b", i, pc, link_addr, flush, exec_active);
      check16("rnd_pc", pc, m_pc);
      check16("rnd_link", link_addr, m_link);
      check1("rnd_flush", flush, m_flush);
      check1("rnd_exec", exec_active, m_in_exec);
    end

    // ---- reset asserted between edges while in EXEC_ONE ----
    clear_inputs();
    step();                       // leave any pending EXEC_ONE
    jr = 1; rs_data = 16'h0040;
    step();
    jr = 0; exec = 1; rs_data = 16'h0080;
    step();
    $display("mid-exec entry: pc=%h exec_active=%b", pc, exec_active);
    check16("midexec_pc", pc, 16'h0080);
    check1("midexec_active", exec_active, 1'b1);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;                           // still well before the next edge
    $display("async reset: pc=%h exec_active=%b", pc, exec_active);
    check16("async_rst_pc", pc, 16'h0000);
    check1("async_rst_exec", exec_active, 1'b0);
    check1("async_rst_flush", flush, 1'b0);
    check16("async_rst_link", link_addr, 16'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    $display("after reset: pc=%h flush=%b exec_active=%b", pc, flush, exec_active);
    check16("post_rst_pc", pc, 16'h0001);
    check1("post_rst_flush", flush, 1'b0);
    check1("post_rst_exec", exec_active, 1'b0);
    step();
    check16("post_rst_pc2", pc, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset; one clock only.
REQ-003 stall  input  1  high = hold all state this cycle.
REQ-004 branch, jal, jr, exec  input  1 each  decoded control for the instruction at pc.
REQ-005 cond  input  3  branch condition code.
REQ-006 flag  input  3  {Z,V,N} = flag[2], flag[1], flag[0].
REQ-007 br_offset  input  8  signed branch displacement.
REQ-008 jal_offset  input  12  signed jump displacement.
REQ-009 rs_data  input  16  register target for jr/exec.
REQ-010 pc  output  16  registered address of the instruction being decoded.
REQ-011 link_addr  output  16  registered return address written by jal.
REQ-012 flush  output  1  registered one-cycle pulse after any redirect.
REQ-013 exec_active  output  1  high while the single EXEC target instruction is in flight.

Function
REQ-014 The FSM SHALL have two states: RUN, EXEC_ONE; exec_active = (state==EXEC_ONE).
REQ-015 All address arithmetic SHALL be 16-bit, modulo 2^16; offsets are sign-extended to 16 bits; seq = pc+1.
REQ-016 Branch taken SHALL be decided per cond: 000 Z; 001 !Z; 010 !Z&!N; 011 N; 100 Z|(!Z&!N); 101 N|Z; 110 V; 111 always.
REQ-017 In RUN with stall=0, next pc SHALL be, in priority order: jr -> rs_data; jal -> seq+sext(jal_offset); exec -> rs_data; branch&taken -> seq+sext(br_offset); otherwise seq.
REQ-018 On jal (as selected by REQ-017), link_addr SHALL load seq on the same edge; otherwise it holds.
REQ-019 On exec (as selected by REQ-017), the saved return address SHALL load seq and state SHALL go to EXEC_ONE.
REQ-020 In EXEC_ONE with stall=0, branch/jal/jr/exec SHALL be ignored, pc SHALL load the saved return address, and state SHALL return to RUN.
REQ-021 Nested exec is not supported; an exec at the EXEC target SHALL execute as a no-op transfer per REQ-020.
REQ-022 flush SHALL be 1 for exactly the cycle after an edge where pc loaded anything other than seq: taken branch, jal, jr, exec entry, or exec return.
REQ-023 A taken branch whose target equals seq (br_offset=0) SHALL still raise flush.
REQ-024 With stall=1, pc, link_addr, state, and the saved return address SHALL hold, and flush SHALL be 0 on the next edge.
REQ-025 When stall=1, control inputs SHALL be re-evaluated when stall deasserts; no redirect is lost or duplicated.
REQ-026 Latency: the redirect SHALL be visible on pc one edge after the deciding cycle.

Reset
REQ-027 While rst_n=0: pc=0x0000, link_addr=0x0000, flush=0, exec_active=0, state=RUN, saved return=0x0000, independent of clk.
REQ-028 A reset asserted during EXEC_ONE SHALL abandon the return; after release, fetch SHALL resume at 0x0000 in RUN.
REQ-029 After rst_n rises, pc SHALL increment on the first rising edge with stall=0 and no control input asserted.

Verification
REQ-030 Sequential: reset, no controls, 3 edges -> pc 0x0000, 0x0001, 0x0002, 0x0003; flush stays 0.
REQ-031 Branch: pc=0x0010, branch=1, cond=000, flag=100, br_offset=0xFE -> pc=0x000F, flush=1 for one cycle; same stimulus with flag=000 -> pc=0x0011, flush=0.
REQ-032 JAL wrap: pc=0xFFFE, jal=1, jal_offset=0x003 -> pc=0x0002, link_addr=0xFFFF, flush=1.
REQ-033 EXEC: pc=0x0020, exec=1, rs_data=0x0100 -> pc=0x0100 with exec_active=1; next edge (with branch=1, cond=111) -> pc=0x0021, exec_active=0, flush=1 on both cycles.
REQ-034 Stall and priority: jr=1, jal=1, rs_data=0x0555, stall=1 for 2 cycles, then stall=0 -> pc holds for 2 cycles, then pc=0x0555 and link_addr unchanged.
REQ-035 Reset mid-EXEC: enter EXEC_ONE, assert rst_n=0 asynchronously between edges -> pc=0x0000 and exec_active=0 immediately, without waiting for an edge.
